// File: rtl/npu_pool_pkg.sv
// Shared definitions for the average-pooling datapath.
// Holds the default geometry constants, the shift-port width and its clamp
// value, and the accumulate/round/output state encoding.
package npu_pool_pkg;

  localparam int unsigned DataWidthDef  = 8;
  localparam int unsigned DataCopiesDef = 32;
  localparam int unsigned CntWidthDef   = 8;
  localparam int unsigned AccWidthDef   = 24;

  localparam int unsigned ShiftWidth    = 5;
  // Largest meaningful right shift for the default accumulator width.
  localparam int unsigned ShiftClampDef = AccWidthDef - 1;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StRound,
    StOut
  } pool_state_e;

endpackage

// File: rtl/pool_round_sat.sv
// Single-lane round, arithmetic shift and saturate.
// Ports:
//   acc_i   - signed lane accumulator
//   shift_i - right-shift amount, already clamped by the caller
//   res_o   - signed result saturated to DATA_WIDTH
// Rounding adds half an output LSB before the arithmetic shift, so ties round
// toward +inf. One extra guard bit keeps the bias add from wrapping.
module pool_round_sat
  import npu_pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned ACC_WIDTH  = AccWidthDef
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  input  logic        [ShiftWidth-1:0] shift_i,
  output logic signed [DATA_WIDTH-1:0] res_o
);

  localparam int unsigned SumWidth = ACC_WIDTH + 1;
  localparam logic signed [SumWidth-1:0] MaxVal = SumWidth'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SumWidth-1:0] MinVal = SumWidth'(-(1 << (DATA_WIDTH - 1)));

  logic signed [SumWidth-1:0] bias;
  logic signed [SumWidth-1:0] sum;
  logic signed [SumWidth-1:0] shifted;

  always_comb begin
    bias = '0;
    if (shift_i != '0) begin
      bias = {{(SumWidth-1){1'b0}}, 1'b1} << (shift_i - ShiftWidth'(1));
    end
    sum     = {acc_i[ACC_WIDTH-1], acc_i} + bias;
    shifted = sum >>> shift_i;
    if (shifted > MaxVal) begin
      res_o = MaxVal[DATA_WIDTH-1:0];
    end else if (shifted < MinVal) begin
      res_o = MinVal[DATA_WIDTH-1:0];
    end else begin
      res_o = shifted[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/avg_pool_accum.sv
// Average-pooling accumulator.
// Sums sign-extended per-lane products over a programmable window, then
// rounds/shifts/saturates each lane and presents one pooled word per window.
// Ports:
//   i_clk, i_rst_n        - clock, synchronous active-low reset
//   i_start               - abort current work, latch config, begin a window
//   i_win_len, i_shift    - beats per window (0 = 2^CNT_WIDTH), output shift
//   i_valid/o_ready       - product beat handshake, i_mul_result payload
//   o_valid/i_ready       - pooled word handshake, o_data payload
//   o_busy                - any state other than idle
module avg_pool_accum
  import npu_pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DataWidthDef,
  parameter int unsigned DATA_COPIES = DataCopiesDef,
  parameter int unsigned CNT_WIDTH   = CntWidthDef,
  parameter int unsigned ACC_WIDTH   = AccWidthDef
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_start,
  input  logic [CNT_WIDTH-1:0]              i_win_len,
  input  logic [ShiftWidth-1:0]             i_shift,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_mul_result,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [DATA_COPIES*DATA_WIDTH-1:0] o_data,
  output logic                              o_busy
);

  localparam int unsigned ProdWidth = 2 * DATA_WIDTH;
  localparam int unsigned ShiftMax  = (ACC_WIDTH - 1 > 31) ? 31 : ACC_WIDTH - 1;

  pool_state_e                       state_q, state_d;
  logic        [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic        [CNT_WIDTH-1:0]       win_len_q, win_len_d;
  logic        [ShiftWidth-1:0]      shift_q, shift_d;
  logic        [DATA_COPIES*DATA_WIDTH-1:0] data_q, data_d;
  logic signed [ACC_WIDTH-1:0]       acc_q [DATA_COPIES];
  logic signed [ACC_WIDTH-1:0]       acc_d [DATA_COPIES];
  logic        [DATA_COPIES*DATA_WIDTH-1:0] lane_res;

  logic accept;
  logic clr;
  logic load;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_len_d = win_len_q;
    shift_d   = shift_q;
    accept    = 1'b0;
    clr       = 1'b0;
    load      = 1'b0;

    if (i_start) begin
      // Start wins over any simultaneous beat or output handshake.
      state_d   = StAccum;
      clr       = 1'b1;
      win_len_d = i_win_len;
      shift_d   = (32'(i_shift) > ShiftMax) ? ShiftWidth'(ShiftMax) : i_shift;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAccum: begin
          if (i_valid) begin
            accept = 1'b1;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            // Wraps naturally so win_len 0 yields a full 2^CNT_WIDTH window.
            if (cnt_q == win_len_q - CNT_WIDTH'(1)) begin
              state_d = StRound;
            end
          end
        end
        StRound: begin
          load    = 1'b1;
          state_d = StOut;
        end
        StOut: begin
          if (i_ready) begin
            clr     = 1'b1;
            state_d = StAccum;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (clr) begin
      cnt_d = '0;
    end

    for (int i = 0; i < DATA_COPIES; i++) begin
      acc_d[i] = acc_q[i];
      if (clr) begin
        acc_d[i] = '0;
      end else if (accept) begin
        acc_d[i] = acc_q[i] + {{(ACC_WIDTH-ProdWidth){i_mul_result[ProdWidth*i + ProdWidth-1]}},
                               i_mul_result[ProdWidth*i +: ProdWidth]};
      end
    end

    data_d = load ? lane_res : data_q;
  end

  for (genvar g = 0; g < DATA_COPIES; g++) begin : g_lane
    pool_round_sat #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_round_sat (
      .acc_i  (acc_q[g]),
      .shift_i(shift_q),
      .res_o  (lane_res[DATA_WIDTH*g +: DATA_WIDTH])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      win_len_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      for (int i = 0; i < DATA_COPIES; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_len_q <= win_len_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      for (int i = 0; i < DATA_COPIES; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign o_ready = (state_q == StAccum);
  assign o_valid = (state_q == StOut);
  assign o_busy  = (state_q != StIdle);
  assign o_data  = data_q;

endmodule

// File: tb/tb_avg_pool_accum.sv
// Self-checking bench for avg_pool_accum: table-driven windows plus
// hand-written back-pressure, full-length, abort and reset sequences.
// Even lanes carry one product stream, odd lanes another.
module tb_avg_pool_accum;

  localparam int DW = 8;
  localparam int DC = 32;
  localparam int CW = 8;
  localparam int AW = 24;
  localparam int PW = 2 * DW;
  localparam int MW = DC * PW;
  localparam int OW = DC * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] win_len;
  logic [4:0]    shift;
  logic          valid_in;
  logic          ready_out;
  logic [MW-1:0] mul;
  logic          valid_out;
  logic          ready_in;
  logic [OW-1:0] data_out;
  logic          busy;

  always #5 clk = ~clk;

  avg_pool_accum #(
    .DATA_WIDTH (DW),
    .DATA_COPIES(DC),
    .CNT_WIDTH  (CW),
    .ACC_WIDTH  (AW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_win_len   (win_len),
    .i_shift     (shift),
    .i_valid     (valid_in),
    .o_ready     (ready_out),
    .i_mul_result(mul),
    .o_valid     (valid_out),
    .i_ready     (ready_in),
    .o_data      (data_out),
    .o_busy      (busy)
  );

  typedef struct {
    int beats;
    int sh;
    int pe[4];
    int po[4];
    int ee;
    int eo;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  logic [OW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk_mul(input int pe, input int po);
    logic [MW-1:0] r;
    int v;
    for (int i = 0; i < DC; i++) begin
      v = (i % 2 == 0) ? pe : po;
      r[i*PW +: PW] = v[PW-1:0];
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] mk_out(input int ee, input int eo);
    logic [OW-1:0] r;
    int v;
    for (int i = 0; i < DC; i++) begin
      v = (i % 2 == 0) ? ee : eo;
      r[i*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] wl, input logic [4:0] sh);
    start   = 1'b1;
    win_len = wl;
    shift   = sh;
    tick();
    start = 1'b0;
  endtask

  task automatic do_beat(input logic [MW-1:0] m);
    valid_in = 1'b1;
    mul      = m;
    tick();
    valid_in = 1'b0;
  endtask

  // Compare the DUT word against the oldest scoreboard entry.
  task automatic check_out(input string name, output logic [OW-1:0] expw);
    expw = '0;
    if (exp_q.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
    end else begin
      expw = exp_q.pop_front();
      chk(name, data_out, expw);
    end
  endtask

  task automatic wait_out(input string name);
    int n;
    logic [OW-1:0] e;
    n = 0;
    while (!valid_out && n < 40) begin
      tick();
      n++;
    end
    if (!valid_out) chk({name, "_timeout"}, valid_out, 1);
    else check_out(name, e);
  endtask

  task automatic handshake(input string name);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    chk({name, "_valid_drop"}, valid_out, 0);
    chk({name, "_ready_back"}, ready_out, 1);
  endtask

  vec_t vecs[6];

  initial begin
    logic [OW-1:0] e;
    int bad;

    vecs[0] = '{beats:4, sh:2, pe:'{10, 20, 30, 40}, po:'{-10, -20, -30, -40}, ee:25, eo:-25};
    vecs[1] = '{beats:1, sh:0, pe:'{16384, 0, 0, 0}, po:'{-16256, 0, 0, 0}, ee:127, eo:-128};
    vecs[2] = '{beats:2, sh:1, pe:'{3, 0, 0, 0}, po:'{-3, 0, 0, 0}, ee:2, eo:-1};
    vecs[3] = '{beats:3, sh:0, pe:'{50, 50, 27, 0}, po:'{-50, -50, -29, 0}, ee:127, eo:-128};
    vecs[4] = '{beats:4, sh:31, pe:'{32767, 32767, 32767, 32767},
                po:'{-32768, -32768, -32768, -32768}, ee:0, eo:0};
    vecs[5] = '{beats:4, sh:3, pe:'{4, 4, 4, 4}, po:'{-4, -4, -4, 0}, ee:2, eo:-1};

    rst_n    = 1'b0;
    start    = 1'b0;
    win_len  = '0;
    shift    = '0;
    valid_in = 1'b0;
    mul      = '0;
    ready_in = 1'b0;
    tick();
    tick();
    chk("rst_ready", ready_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven windows.
    for (int v = 0; v < 6; v++) begin
      do_start(CW'(vecs[v].beats), 5'(vecs[v].sh));
      exp_q.push_back(mk_out(vecs[v].ee, vecs[v].eo));
      chk($sformatf("v%0d_ready_after_start", v), ready_out, 1);
      chk($sformatf("v%0d_busy_after_start", v), busy, 1);
      for (int k = 0; k < vecs[v].beats; k++) begin
        do_beat(mk_mul(vecs[v].pe[k], vecs[v].po[k]));
      end
      chk($sformatf("v%0d_round_valid", v), valid_out, 0);
      chk($sformatf("v%0d_round_ready", v), ready_out, 0);
      tick();
      chk($sformatf("v%0d_valid_latency", v), valid_out, 1);
      check_out($sformatf("v%0d_data", v), e);
      handshake($sformatf("v%0d", v));
    end

    // Continuous window with the retained configuration from vecs[5].
    exp_q.push_back(mk_out(2, -1));
    for (int k = 0; k < 4; k++) do_beat(mk_mul(vecs[5].pe[k], vecs[5].po[k]));
    wait_out("cont_data");
    handshake("cont");

    // Gaps between beats, then downstream back-pressure.
    do_start(CW'(4), 5'd2);
    exp_q.push_back(mk_out(25, -25));
    for (int k = 0; k < 4; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        mul = {16{$urandom}};
        tick();
        chk("bp_gap_ready", ready_out, 1);
      end
      do_beat(mk_mul(10 * (k + 1), -10 * (k + 1)));
    end
    chk("bp_round_valid", valid_out, 0);
    tick();
    chk("bp_valid_latency", valid_out, 1);
    check_out("bp_data", e);
    for (int c = 0; c < 5; c++) begin
      valid_in = 1'b1;
      mul      = mk_mul(99, 99);
      tick();
      chk("bp_hold_data", data_out, e);
      chk("bp_hold_valid", valid_out, 1);
      chk("bp_hold_ready", ready_out, 0);
    end
    valid_in = 1'b0;
    handshake("bp");

    // Full 2^CNT_WIDTH window selected by win_len 0.
    do_start(CW'(0), 5'd8);
    exp_q.push_back(mk_out(127, 127));
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (ready_out !== 1'b1) bad++;
      do_beat(mk_mul(16384, 16384));
    end
    chk("full_all_beats_accepted", bad, 0);
    chk("full_stops_after_256", ready_out, 0);
    tick();
    chk("full_valid", valid_out, 1);
    check_out("full_data", e);
    handshake("full");

    // Abort mid-window; the first two beats must vanish.
    do_start(CW'(4), 5'd2);
    do_beat(mk_mul(100, 100));
    do_beat(mk_mul(100, 100));
    do_start(CW'(4), 5'd2);
    exp_q.push_back(mk_out(4, 4));
    for (int k = 0; k < 4; k++) do_beat(mk_mul(4, 4));
    wait_out("abort_data");
    handshake("abort");

    // Reset while a word is waiting in OUT.
    do_start(CW'(1), 5'd0);
    exp_q.push_back(mk_out(5, -5));
    do_beat(mk_mul(5, -5));
    tick();
    chk("rstout_valid_before", valid_out, 1);
    check_out("rstout_data_before", e);
    rst_n = 1'b0;
    tick();
    chk("rstout_valid", valid_out, 0);
    chk("rstout_data", data_out, 0);
    chk("rstout_busy", busy, 0);
    chk("rstout_ready", ready_out, 0);
    rst_n    = 1'b1;
    valid_in = 1'b1;
    mul      = mk_mul(9, 9);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rstout_idle_ready", ready_out, 0);
      chk("rstout_idle_busy", busy, 0);
    end
    valid_in = 1'b0;
    do_start(CW'(1), 5'd0);
    exp_q.push_back(mk_out(7, 7));
    do_beat(mk_mul(7, 7));
    wait_out("post_rst_data");
    handshake("post_rst");

    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avg_pool_accum.md
# avg_pool_accum

Consumer of the per-lane products emitted by the average-pooling multiplier stage. It sign-extends each lane's `2*DATA_WIDTH` product and accumulates it over a programmable pooling window. It then rounds, shifts and saturates each sum back to `DATA_WIDTH` and delivers one `DATA_COPIES`-lane pooled word per window over a valid/ready handshake to the output buffer.

## Interface
Parameters:
- `DATA_WIDTH`, 8: output lane width; the input product lane width is `2*DATA_WIDTH`.
- `DATA_COPIES`, 32: number of parallel lanes.
- `CNT_WIDTH`, 8: window-length counter width.
- `ACC_WIDTH`, 24: signed accumulator width. It must be ≥ `2*DATA_WIDTH + CNT_WIDTH`.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst_n`, in, 1: reset. Synchronous and active-low.
- `i_start`, in, 1: one-cycle pulse. Latches the configuration, clears the accumulators and enters ACCUM.
- `i_win_len`, in, `CNT_WIDTH`: number of product beats per window. The value 0 means `2^CNT_WIDTH`.
- `i_shift`, in, 5: right-shift amount for the output. Values above `ACC_WIDTH-1` clamp to `ACC_WIDTH-1`.
- `i_valid`, in, 1: product beat valid.
- `o_ready`, out, 1: block can accept a product beat.
- `i_mul_result`, in, `DATA_COPIES*2*DATA_WIDTH`: signed products. Lane i occupies bits `[2*DATA_WIDTH*i +: 2*DATA_WIDTH]`.
- `o_valid`, out, 1: pooled word valid.
- `i_ready`, in, 1: downstream accepts the pooled word.
- `o_data`, out, `DATA_COPIES*DATA_WIDTH`: signed pooled lanes. Lane i occupies bits `[DATA_WIDTH*i +: DATA_WIDTH]`.
- `o_busy`, out, 1: high in any state other than IDLE.

## Operation
State machine:
- IDLE: `o_ready`=0. On `i_start`, go to ACCUM.
- ACCUM: `o_ready`=1. A beat is accepted when `i_valid && o_ready`.
  - On each accepted beat: `acc[i] += sext(product[i])` and `cnt++`.
  - On the beat accepted while `cnt == win_len-1` (modulo `2^CNT_WIDTH`), go to ROUND.
- ROUND: `o_ready`=0. Register `o_data` from the final accumulators, then go to OUT.
- OUT: `o_valid`=1 and `o_data` is held stable.
  - On `i_ready`: clear `acc` and `cnt`, return to ACCUM with the latched configuration retained (continuous windows).

`i_start` rules:
- `i_start` in any state aborts the current work. It clears `acc`, `cnt` and `o_valid`, re-latches `i_win_len` and `i_shift`, and enters ACCUM.
- `i_start` has priority over a simultaneous beat acceptance or output handshake. An aborted output word is dropped.

Arithmetic per lane:
- `s = shift`. Compute `r = (acc + (s>0 ? 1<<(s-1) : 0)) >>> s`, an arithmetic shift, i.e. round half toward +inf.
- Saturate `r` to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], which is [-128, 127] at defaults.
- The accumulator cannot overflow at the parameter constraint, so no accumulator saturation is required.

`i_mul_result` is sampled only on accepted beats. Beats presented in IDLE, ROUND or OUT are not consumed.

## Timing
- Reset: state IDLE; `o_ready`=0, `o_valid`=0, `o_data`=0, `o_busy`=0; `acc`=0, `cnt`=0.
- `i_start` sampled at edge t: `o_ready`=1 and `o_busy`=1 from cycle t+1.
- Last beat accepted at edge t: ROUND during cycle t+1; `o_valid`=1 with `o_data` valid from cycle t+2.
- Output handshake at edge t: `o_valid`=0 and `o_ready`=1 in cycle t+1.
- Throughput: one beat per cycle in ACCUM, plus two cycles of overhead per window. Back-pressure stalls ACCUM entry indefinitely.
- Reset asserted mid-operation returns all outputs to their reset values on the next edge.

## Structure
- Shared package `npu_pool_pkg` holds:
  - the state enum (IDLE, ACCUM, ROUND, OUT);
  - the default `DATA_WIDTH`, `DATA_COPIES`, `CNT_WIDTH` and `ACC_WIDTH` constants;
  - the shift-clamp constant.
- One natural sub-module, `pool_round_sat`: combinational round, shift and saturate for one lane. It is instantiated `DATA_COPIES` times in a generate loop.
- The top level contains the FSM, the counter, the configuration registers, the lane accumulators and the output register.

## Test plan
- Basic window: `win_len`=4, `shift`=2; lane0 products 10,20,30,40; lane1 products -10,-20,-30,-40 → lane0=25, lane1=-25; `o_valid` rises two cycles after the fourth beat.
- Saturation: `win_len`=1, `shift`=0; lane0 16384, lane1 -16256 → lane0=127, lane1=-128.
- Back-pressure and gaps: beats separated by random `i_valid` gaps, then `i_ready` held low for 5 cycles → result identical to the contiguous case; `o_data` stable and `o_ready`=0 throughout; `o_ready`=1 the cycle after the handshake.
- Full-length window: `win_len`=0, `shift`=8, 256 beats of 16384 on all lanes → all lanes 127; exactly 256 beats consumed.
- Abort: `i_start` after 2 of 4 beats, then 4 new beats of 4 with `shift`=2 → output 4; the first two beats have no effect.
- Reset mid-OUT: `i_rst_n`=0 while `o_valid`=1 → next cycle `o_valid`=0, `o_data`=0, `o_busy`=0; no beats accepted until `i_start`.
